// File: rtl/fifo_read_ctrl.sv
// Read-side controller for an async FIFO: read pointers, empty/level flags, rvalid/rready data handshake.
// Latency: a memory word is presented one rclk after its read strobe; flags track rq2_wptr one cycle later.
// Backpressure: while rvalid && !rready no new read issues, so the memory output register holds the word.
//
// Ports:
//   rclk, rrst_n   read clock, asynchronous active-low reset
//   rq2_wptr       Gray write pointer, already synchronized into rclk
//   rready         consumer accepts the word currently on memory rdata
//   rclk_en, raddr read strobe and address to the memory
//   rptr           registered Gray read pointer for the write-domain synchronizer
//   rempty         FIFO empty (also gates the memory read port)
//   rvalid         memory rdata holds an unconsumed word
//   raempty        fill level at or below AEMPTY_THRESH
//   rlevel         words in memory not yet fetched (0..DEPTH)
module fifo_read_ctrl #(
    parameter int ADDR_SIZE     = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic [ADDR_SIZE:0]   rq2_wptr,
    input  logic                 rready,
    output logic                 rclk_en,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic                 rempty,
    output logic                 rvalid,
    output logic                 raempty,
    output logic [ADDR_SIZE:0]   rlevel
);
    localparam int PW = ADDR_SIZE + 1;
    localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;

    // A read may issue only when data exists and the output slot is free
    // or being freed this cycle; this keeps a held word from being overwritten.
    assign rclk_en    = !rempty && (!rvalid || rready);
    assign raddr      = rbin[ADDR_SIZE-1:0];
    assign rbin_next  = rbin + PW'(rclk_en);
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end
    end

    // Modulo arithmetic on the extra wrap bit gives 0..DEPTH for any pointer jump.
    assign level_next = wbin - rbin_next;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            rvalid  <= 1'b0;
            rlevel  <= '0;
            raempty <= 1'b1;
        end else begin
            rbin    <= rbin_next;
            rptr    <= rgray_next;
            // Compare against the post-increment pointer so empty rises on the
            // same edge that issues the last word.
            rempty  <= (rgray_next == rq2_wptr);
            if (rclk_en) begin
                rvalid <= 1'b1;
            end else if (rready) begin
                rvalid <= 1'b0;
            end
            rlevel  <= level_next;
            raempty <= (level_next <= THRESH);
        end
    end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;
    logic       rclk = 1'b0;
    logic       rrst_n;
    logic [4:0] rq2_wptr;
    logic       rready;
    logic       rclk_en;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       rvalid;
    logic       raempty;
    logic [4:0] rlevel;

    logic [7:0] mem [16];
    logic [7:0] rdata;
    logic [3:0] addr_log [16];
    logic [4:0] rptr_log [16];

    int n_tests = 0;
    int n_fail  = 0;
    int rb = 0;
    int wb = 0;

    fifo_read_ctrl #(.ADDR_SIZE(4), .AEMPTY_THRESH(2)) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .rq2_wptr (rq2_wptr),
        .rready   (rready),
        .rclk_en  (rclk_en),
        .raddr    (raddr),
        .rptr     (rptr),
        .rempty   (rempty),
        .rvalid   (rvalid),
        .raempty  (raempty),
        .rlevel   (rlevel)
    );

    always #5 rclk = ~rclk;

    // Memory with a one-cycle registered read port.
    always @(posedge rclk) begin
        if (rclk_en) rdata <= mem[raddr];
    end

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #2;
    endtask

    // Write n words behind the read pointer, then drain them with rready=1.
    task automatic run_burst(input string tag, input int n, input logic [7:0] seed);
        int base;
        base = rb;
        for (int i = 0; i < n; i++) mem[4'((base + i) % 16)] = seed + 8'(i);
        wb = (wb + n) % 32;
        rq2_wptr = gray(wb);
        rready = 1'b1;
        #1;
        check({tag, "/empty_before"}, 32'(rempty), 32'd1);
        step();
        check({tag, "/empty_fall"}, 32'(rempty), 32'd0);
        check({tag, "/level_start"}, 32'(rlevel), 32'(n));
        check({tag, "/aempty_start"}, 32'(raempty), 32'(n <= 2));
        for (int k = 0; k < n; k++) begin
            check({tag, "/rclk_en"}, 32'(rclk_en), 32'd1);
            check({tag, "/raddr"}, 32'(raddr), 32'((base + k) % 16));
            addr_log[k] = raddr;
            step();
            rb = (rb + 1) % 32;
            rptr_log[k] = rptr;
            check({tag, "/data"}, 32'({rvalid, rdata}), 32'({1'b1, seed + 8'(k)}));
            check({tag, "/level"}, 32'(rlevel), 32'(n - k - 1));
            check({tag, "/aempty"}, 32'(raempty), 32'((n - k - 1) <= 2));
            check({tag, "/rptr"}, 32'(rptr), 32'(gray(rb)));
        end
        check({tag, "/empty_rise"}, 32'(rempty), 32'd1);
        check({tag, "/rclk_en_off"}, 32'(rclk_en), 32'd0);
        step();
        check({tag, "/rvalid_drop"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        int fetches;
        rrst_n   = 1'b0;
        rq2_wptr = '0;
        rready   = 1'b0;

        // 1: reset state, and idle behaviour regardless of rready
        repeat (2) step();
        check("t1/reset", 32'({rempty, rvalid, rclk_en, raempty, rlevel, raddr, rptr}),
              32'({1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 4'd0, 5'd0}));
        rrst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rready = 1'(i % 2);
            step();
            check("t1/idle", 32'({rempty, rvalid, rclk_en, raempty, rlevel}),
                  32'({1'b1, 1'b0, 1'b0, 1'b1, 5'd0}));
        end

        // 2: five words streamed back-to-back
        run_burst("t2", 5, 8'hD0);
        check("t2/rptr_end", 32'(rptr), 32'(5'b00111));

        // 3: backpressure, three words with rready low
        rready = 1'b0;
        for (int i = 0; i < 3; i++) mem[4'(5 + i)] = 8'h30 + 8'(i);
        wb = 8;
        rq2_wptr = 5'b01100;
        step();
        check("t3/empty_fall", 32'(rempty), 32'd0);
        check("t3/level_start", 32'(rlevel), 32'd3);
        fetches = 0;
        for (int i = 0; i < 6; i++) begin
            if (rclk_en) fetches++;
            step();
            check("t3/hold", 32'({rvalid, rdata}), 32'({1'b1, 8'h30}));
            check("t3/stall_level", 32'(rlevel), 32'd2);
        end
        check("t3/fetches", 32'(fetches), 32'd1);
        rready = 1'b1;
        #1;
        check("t3/release_en", 32'(rclk_en), 32'd1);
        step();
        check("t3/d1", 32'({rvalid, rdata}), 32'({1'b1, 8'h31}));
        step();
        check("t3/d2", 32'({rvalid, rdata}), 32'({1'b1, 8'h32}));
        check("t3/empty_rise", 32'(rempty), 32'd1);
        step();
        check("t3/rvalid_drop", 32'(rvalid), 32'd0);
        rb = 8;

        // 4: full FIFO, level 16 down to 0 with almost-empty at 2,1,0
        run_burst("t4", 16, 8'h40);

        // 5: walk read pointer to 30, then four words across the wrap
        run_burst("t5a", 6, 8'h60);
        run_burst("t5", 4, 8'h70);
        check("t5/addr0", 32'(addr_log[0]), 32'd14);
        check("t5/addr1", 32'(addr_log[1]), 32'd15);
        check("t5/addr2", 32'(addr_log[2]), 32'd0);
        check("t5/addr3", 32'(addr_log[3]), 32'd1);
        check("t5/gray31", 32'(rptr_log[0]), 32'(5'b10000));
        check("t5/gray0", 32'(rptr_log[1]), 32'd0);
        check("t5/rptr_end", 32'(rptr), 32'(5'b00011));

        // 6: asynchronous reset with a held word and level 7
        rready = 1'b0;
        for (int i = 0; i < 8; i++) mem[4'(2 + i)] = 8'h90 + 8'(i);
        wb = 10;
        rq2_wptr = 5'b01111;
        step();
        step();
        check("t6/pre_state", 32'({rvalid, rlevel, rdata}), 32'({1'b1, 5'd7, 8'h90}));
        #3;
        rrst_n = 1'b0;
        #1;
        check("t6/async_reset", 32'({rempty, rvalid, rclk_en, raempty, rlevel, raddr, rptr}),
              32'({1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 4'd0, 5'd0}));
        rq2_wptr = '0;
        wb = 0;
        rb = 0;
        step();
        rrst_n = 1'b1;
        step();
        check("t6/after_release", 32'({rempty, rvalid, rlevel}), 32'({1'b1, 1'b0, 5'd0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
